sfp_acc_bank: RTL and testbench

//  Next-generation special function processor behind the systolic array's psum outputs.

---
 rtl/sfp_pkg.sv | 104 ++++++++++
 rtl/sfp_acc_bank_lane.sv | 52 +++++
 rtl/sfp_acc_bank.sv | 141 ++++++++++++++
 tb/tb_sfp_acc_bank.sv | 393 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sfp_pkg.sv
// Shared types, limits and arithmetic helpers for the psum accumulator bank.
// Widths are fixed here so the lane helpers and the bank agree on lane format.
package sfp_pkg;

   localparam int PSUM_BW = 16;
   localparam int OUT_BW  = 8;

   typedef enum logic [1:0] {
      MODE_NONE = 2'd0,
      MODE_RELU = 2'd1,
      MODE_SIG  = 2'd2,
      MODE_TANH = 2'd3
   } mode_e;

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_CLEAR = 1'b1
   } state_e;

   localparam logic signed [PSUM_BW-1:0] PSUM_MAX = {1'b0, {(PSUM_BW-1){1'b1}}};
   localparam logic signed [PSUM_BW-1:0] PSUM_MIN = {1'b1, {(PSUM_BW-1){1'b0}}};
   localparam logic signed [OUT_BW-1:0]  OUT_MAX  = {1'b0, {(OUT_BW-1){1'b1}}};
   localparam logic signed [OUT_BW-1:0]  OUT_MIN  = {1'b1, {(OUT_BW-1){1'b0}}};
   localparam logic signed [PSUM_BW:0]   OUT_HI   = (PSUM_BW+1)'(OUT_MAX);
   localparam logic signed [PSUM_BW:0]   OUT_LO   = (PSUM_BW+1)'(OUT_MIN);
   localparam logic signed [PSUM_BW-1:0] SIG_LO   = PSUM_BW'(-2048);
   localparam logic signed [PSUM_BW-1:0] SIG_HI   = PSUM_BW'(2047);
   localparam logic        [PSUM_BW-1:0] TANH_SAT = PSUM_BW'(1023);

   function automatic logic [OUT_BW-1:0] sig_lut(input logic [3:0] idx);
      logic [OUT_BW-1:0] v;
      case (idx)
         4'd0:    v = 8'd4;
         4'd1:    v = 8'd6;
         4'd2:    v = 8'd9;
         4'd3:    v = 8'd13;
         4'd4:    v = 8'd19;
         4'd5:    v = 8'd28;
         4'd6:    v = 8'd40;
         4'd7:    v = 8'd53;
         4'd8:    v = 8'd66;
         4'd9:    v = 8'd79;
         4'd10:   v = 8'd91;
         4'd11:   v = 8'd101;
         4'd12:   v = 8'd109;
         4'd13:   v = 8'd115;
         4'd14:   v = 8'd120;
         default: v = 8'd124;
      endcase
      return v;
   endfunction

   function automatic logic [OUT_BW-1:0] tanh_lut(input logic [2:0] idx);
      logic [OUT_BW-1:0] v;
      case (idx)
         3'd0:    v = 8'd8;
         3'd1:    v = 8'd24;
         3'd2:    v = 8'd40;
         3'd3:    v = 8'd56;
         3'd4:    v = 8'd72;
         3'd5:    v = 8'd88;
         3'd6:    v = 8'd104;
         default: v = 8'd127;
      endcase
      return v;
   endfunction

   function automatic logic signed [PSUM_BW-1:0] sat_add(input logic signed [PSUM_BW-1:0] a,
                                                         input logic signed [PSUM_BW-1:0] b);
      logic signed [PSUM_BW:0] s;
      s = {a[PSUM_BW-1], a} + {b[PSUM_BW-1], b};
      if (s[PSUM_BW] != s[PSUM_BW-1]) begin
         return s[PSUM_BW] ? PSUM_MIN : PSUM_MAX;
      end
      return s[PSUM_BW-1:0];
   endfunction

   function automatic logic signed [OUT_BW-1:0] sat_out(input logic signed [PSUM_BW:0] v);
      if (v > OUT_HI) begin
         return OUT_MAX;
      end
      if (v < OUT_LO) begin
         return OUT_MIN;
      end
      return v[OUT_BW-1:0];
   endfunction

   // Round half up; one guard bit keeps the rounding add from overflowing.
   function automatic logic signed [OUT_BW-1:0] requant(input logic signed [PSUM_BW-1:0] v,
                                                        input logic [3:0] sh);
      logic signed [PSUM_BW:0] w;
      logic signed [PSUM_BW:0] rnd;
      logic signed [PSUM_BW:0] r;
      w = {v[PSUM_BW-1], v};
      if (sh == 4'd0) begin
         r = w;
      end else begin
         rnd = {{PSUM_BW{1'b0}}, 1'b1} << (sh - 4'd1);
         r   = (w + rnd) >>> sh;
      end
      return sat_out(r);
   endfunction

endpackage

// File: rtl/sfp_acc_bank_lane.sv
// One output lane: activation select, LUT lookup, requantization and saturation.
// Purely combinational; instantiated once per column by the bank.
module sfp_act_lane
   import sfp_pkg::*;
(
   input  logic [PSUM_BW-1:0] sum,
   input  logic [1:0]         mode,
   input  logic [3:0]         shift,
   output logic [OUT_BW-1:0]  out
);

   logic signed [PSUM_BW-1:0] s_sig;
   logic signed [PSUM_BW-1:0] relu;
   logic        [3:0]         sig_idx;
   logic        [PSUM_BW-1:0] mag;
   logic        [2:0]         tanh_idx;
   logic        [OUT_BW-1:0]  tanh_mag;
   logic        [OUT_BW-1:0]  tanh_out;

   always_comb begin
      s_sig = $signed(sum);
      relu  = s_sig[PSUM_BW-1] ? '0 : s_sig;

      // Inside the linear window the index is taken modulo the 16-entry table.
      if (s_sig < SIG_LO) begin
         sig_idx = 4'd0;
      end else if (s_sig > SIG_HI) begin
         sig_idx = 4'd15;
      end else begin
         sig_idx = 4'(s_sig >>> 7) + 4'd8;
      end

      if (s_sig == PSUM_MIN) begin
         mag = PSUM_MAX;
      end else if (s_sig[PSUM_BW-1]) begin
         mag = -s_sig;
      end else begin
         mag = s_sig;
      end
      tanh_idx = (mag > TANH_SAT) ? 3'd7 : mag[9:7];
      tanh_mag = tanh_lut(tanh_idx);
      tanh_out = s_sig[PSUM_BW-1] ? -tanh_mag : tanh_mag;

      case (mode_e'(mode))
         MODE_NONE: out = requant(s_sig, shift);
         MODE_RELU: out = requant(relu, shift);
         MODE_SIG:  out = sig_lut(sig_idx);
         default:   out = tanh_out;
      endcase
   end

endmodule

// File: rtl/sfp_acc_bank.sv
// Multi-entry psum accumulator with per-beat activation/requant and valid/ready on both sides.
//
//   state    | meaning
//   ST_RUN   | accepting beats, accumulating and emitting outputs
//   ST_CLEAR | sweeping cnt over all entries writing zero; input stalled
module sfp_acc_bank
   import sfp_pkg::*;
#(
   parameter int COL   = 8,
   parameter int DEPTH = 16,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    clr,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [COL*PSUM_BW-1:0]  in_data,
   input  logic [ADDR_W-1:0]       in_addr,
   input  logic                    acc_en,
   input  logic                    emit,
   input  logic [1:0]              mode,
   input  logic [3:0]              shift,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [COL*OUT_BW-1:0]   out_data,
   output logic [ADDR_W-1:0]       out_addr,
   output logic                    busy
);

   state_e                state_q, state_d;
   logic [ADDR_W-1:0]     cnt_q, cnt_d;
   logic [PSUM_BW-1:0]    entry_q [DEPTH][COL];
   logic [PSUM_BW-1:0]    entry_d [DEPTH][COL];
   logic                  out_valid_q, out_valid_d;
   logic [COL*OUT_BW-1:0] out_data_q, out_data_d;
   logic [ADDR_W-1:0]     out_addr_q, out_addr_d;

   logic [PSUM_BW-1:0]    sum_lane [COL];
   logic [COL*OUT_BW-1:0] act;
   logic                  accept;
   logic                  addr_ok;

   if (DEPTH == (1 << ADDR_W)) begin : g_addr_full
      assign addr_ok = 1'b1;
   end else begin : g_addr_part
      assign addr_ok = (32'(in_addr) < DEPTH);
   end

   assign in_ready  = (state_q == ST_RUN) & ~clr & (~out_valid_q | out_ready);
   assign accept    = in_valid & in_ready;
   assign busy      = (state_q == ST_CLEAR);
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_addr  = out_addr_q;

   // Read-modify-write of the addressed entry happens within the accepting cycle.
   always_comb begin
      for (int k = 0; k < COL; k++) begin
         sum_lane[k] = sat_add(acc_en ? entry_q[in_addr][k] : '0,
                               in_data[k*PSUM_BW +: PSUM_BW]);
      end
   end

   for (genvar k = 0; k < COL; k++) begin : g_lane
      sfp_act_lane u_lane (
         .sum   (sum_lane[k]),
         .mode  (mode),
         .shift (shift),
         .out   (act[k*OUT_BW +: OUT_BW])
      );
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      entry_d     = entry_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_addr_d  = out_addr_q;

      case (state_q)
         ST_RUN: begin
            if (clr) begin
               state_d = ST_CLEAR;
               cnt_d   = '0;
            end
         end
         default: begin
            for (int k = 0; k < COL; k++) begin
               entry_d[cnt_q][k] = '0;
            end
            if (clr) begin
               cnt_d = '0;
            end else if (cnt_q == ADDR_W'(DEPTH-1)) begin
               state_d = ST_RUN;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
      endcase

      if (accept && addr_ok) begin
         for (int k = 0; k < COL; k++) begin
            entry_d[in_addr][k] = sum_lane[k];
         end
      end

      if (accept && emit && addr_ok) begin
         out_valid_d = 1'b1;
         out_data_d  = act;
         out_addr_d  = in_addr;
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_RUN;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_addr_q  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            for (int k = 0; k < COL; k++) begin
               entry_q[i][k] <= '0;
            end
         end
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_addr_q  <= out_addr_d;
         entry_q     <= entry_d;
      end
   end

endmodule

// File: tb/tb_sfp_acc_bank.sv
// Scoreboard bench for sfp_acc_bank: directed cases plus randomized beats against an
// integer reference model of accumulate/saturate/activate/requantize.
module tb_sfp_acc_bank;

   localparam int COL   = 8;
   localparam int DEPTH = 16;
   localparam int NOEXP = 99999;

   typedef struct {
      int          addr;
      logic [63:0] data;
   } exp_t;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         clr = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [127:0] in_data = '0;
   logic [3:0]   in_addr = '0;
   logic         acc_en = 1'b0;
   logic         emit = 1'b0;
   logic [1:0]   mode = '0;
   logic [3:0]   shift = '0;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [63:0]  out_data;
   logic [3:0]   out_addr;
   logic         busy;

   int   n_cmp = 0;
   int   n_fail = 0;
   int   mem [DEPTH][COL];
   int   lv [COL];
   exp_t sb_q [$];
   exp_t last_exp;
   bit   force_hold = 1'b0;
   bit   rand_rdy = 1'b0;

   int   sig_t [16] = '{4, 6, 9, 13, 19, 28, 40, 53, 66, 79, 91, 101, 109, 115, 120, 124};
   int   tanh_t [8] = '{8, 24, 40, 56, 72, 88, 104, 127};

   always #5 clk = ~clk;

   sfp_acc_bank #(.COL(COL), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .reset     (reset),
      .clr       (clr),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_addr   (in_addr),
      .acc_en    (acc_en),
      .emit      (emit),
      .mode      (mode),
      .shift     (shift),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_addr  (out_addr),
      .busy      (busy)
   );

   function automatic int clamp(input int v, input int lo, input int hi);
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

   function automatic int m_requant(input int v, input int sh);
      int r;
      if (sh == 0) r = v;
      else r = (v + (1 << (sh - 1))) >>> sh;
      return clamp(r, -128, 127);
   endfunction

   function automatic int m_lane(input int s, input int md, input int sh);
      int i;
      int a;
      case (md)
         0: return m_requant(s, sh);
         1: return m_requant((s < 0) ? 0 : s, sh);
         2: begin
            if (s < -2048) i = 0;
            else if (s > 2047) i = 15;
            else i = ((s >>> 7) + 8) & 15;
            return sig_t[i];
         end
         default: begin
            a = (s < 0) ? -s : s;
            if (a > 32767) a = 32767;
            i = (a > 1023) ? 7 : ((a >> 7) & 7);
            return (s < 0) ? -tanh_t[i] : tanh_t[i];
         end
      endcase
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic zero_model();
      for (int i = 0; i < DEPTH; i++)
         for (int k = 0; k < COL; k++)
            mem[i][k] = 0;
   endtask

   task automatic set_lanes(input int v0, input int rest);
      lv[0] = v0;
      for (int k = 1; k < COL; k++) lv[k] = rest;
   endtask

   task automatic send_beat(input int addr, input bit acc, input bit em, input int md,
                            input int sh, input int exp0);
      int   waited;
      int   s;
      int   r;
      exp_t e;
      @(negedge clk);
      in_valid = 1'b1;
      in_addr  = 4'(addr);
      acc_en   = acc;
      emit     = em;
      mode     = 2'(md);
      shift    = 4'(sh);
      for (int k = 0; k < COL; k++) in_data[16*k +: 16] = 16'(lv[k]);
      waited = 0;
      #4;
      while (!in_ready && waited < 100) begin
         @(negedge clk);
         #4;
         waited++;
      end
      if (!in_ready) begin
         n_cmp++;
         n_fail++;
         $display("FAIL accept_timeout: in_ready held 0 for addr %0d, expected 1", addr);
         in_valid = 1'b0;
         return;
      end
      e.addr = addr;
      e.data = '0;
      for (int k = 0; k < COL; k++) begin
         s = acc ? mem[addr][k] + lv[k] : lv[k];
         s = clamp(s, -32768, 32767);
         mem[addr][k] = s;
         r = m_lane(s, md, sh);
         if (k == 0 && exp0 != NOEXP) r = exp0;
         e.data[8*k +: 8] = 8'(r);
      end
      if (em) begin
         sb_q.push_back(e);
         last_exp = e;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic pulse_clr();
      @(negedge clk);
      clr = 1'b1;
      @(posedge clk);
      #1;
      clr = 1'b0;
      zero_model();
   endtask

   task automatic count_busy(output int n);
      n = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         #4;
         if (!busy) break;
         n++;
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Output-side ready driver.
   initial begin
      forever begin
         @(negedge clk);
         out_ready = force_hold ? 1'b0 : (rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1);
      end
   end

   // Monitor: pops the scoreboard on every output transfer.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #4;
         if (!reset && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
               n_cmp++;
               n_fail++;
               $display("FAIL unexpected_output: addr %0d data %h, expected no output", out_addr, out_data);
            end else begin
               e = sb_q.pop_front();
               check("out_addr", 64'(out_addr), 64'(e.addr));
               check("out_data", out_data, e.data);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int       nb;
      int       v;
      int       addr;
      exp_t     held;
      logic signed [15:0] t16;

      zero_model();
      set_lanes(0, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      #4;
      check("rst_out_valid", 64'(out_valid), 64'(0));
      check("rst_out_data", out_data, 64'(0));
      check("rst_out_addr", 64'(out_addr), 64'(0));
      check("rst_busy", 64'(busy), 64'(0));
      @(negedge clk);
      reset = 1'b0;
      #4;
      check("rst_in_ready", 64'(in_ready), 64'(1));

      // Basic pass-through.
      set_lanes(100, 0);
      send_beat(3, 0, 1, 0, 0, 100);

      // Accumulate to saturation, then requant overflow.
      set_lanes(30000, 0);
      send_beat(5, 0, 0, 0, 0, NOEXP);
      send_beat(5, 1, 1, 0, 8, 127);

      // Interleaved accumulation with ReLU.
      set_lanes(-50, 3);
      send_beat(1, 1, 0, 1, 0, NOEXP);
      set_lanes(40, -9);
      send_beat(2, 1, 0, 1, 0, NOEXP);
      set_lanes(20, 4);
      send_beat(1, 1, 1, 1, 0, 0);
      set_lanes(40, 1);
      send_beat(2, 1, 1, 1, 0, 80);

      // Output backpressure.
      idle(3);
      force_hold = 1'b1;
      set_lanes(11, 2);
      send_beat(7, 0, 1, 0, 0, 11);
      held = last_exp;
      @(negedge clk);
      set_lanes(-5, 0);
      in_valid = 1'b1;
      in_addr  = 4'd9;
      acc_en   = 1'b0;
      emit     = 1'b1;
      mode     = 2'd0;
      shift    = 4'd0;
      for (int k = 0; k < COL; k++) in_data[16*k +: 16] = 16'(lv[k]);
      #4;
      check("hold_in_ready", 64'(in_ready), 64'(0));
      check("hold_out_data", out_data, held.data);
      repeat (2) begin
         @(negedge clk);
         #4;
         check("hold_out_valid", 64'(out_valid), 64'(1));
         check("hold_out_stable", out_data, held.data);
      end
      in_valid   = 1'b0;
      force_hold = 1'b0;
      send_beat(9, 0, 1, 0, 0, -5);

      // Clear sweep: clr beats in_valid, busy lasts DEPTH cycles.
      idle(2);
      @(negedge clk);
      set_lanes(55, 55);
      in_valid = 1'b1;
      in_addr  = 4'd4;
      emit     = 1'b1;
      acc_en   = 1'b0;
      for (int k = 0; k < COL; k++) in_data[16*k +: 16] = 16'(lv[k]);
      clr = 1'b1;
      #4;
      check("clr_in_ready", 64'(in_ready), 64'(0));
      @(posedge clk);
      #1;
      clr      = 1'b0;
      in_valid = 1'b0;
      zero_model();
      count_busy(nb);
      check("busy_cycles", 64'(nb), 64'(16));
      set_lanes(7, 0);
      send_beat(5, 1, 1, 0, 0, 7);

      // clr mid-sweep restarts the counter.
      pulse_clr();
      idle(4);
      pulse_clr();
      count_busy(nb);
      check("busy_restart", 64'(nb), 64'(16));

      // LUT modes.
      set_lanes(-4000, 0);
      send_beat(8, 0, 1, 2, 5, 4);
      set_lanes(0, 1500);
      send_beat(8, 0, 1, 2, 0, 66);
      set_lanes(-32768, -600);
      send_beat(10, 0, 1, 3, 0, -127);
      set_lanes(200, 1100);
      send_beat(11, 0, 1, 3, 3, 24);

      // Reset mid-sweep and with an output pending.
      idle(3);
      pulse_clr();
      idle(4);
      force_hold = 1'b1;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      #4;
      check("rst_mid_busy", 64'(busy), 64'(0));
      reset = 1'b0;
      zero_model();
      set_lanes(33, -33);
      force_hold = 1'b0;
      send_beat(6, 0, 1, 0, 0, 33);
      idle(2);
      force_hold = 1'b1;
      set_lanes(44, 0);
      send_beat(6, 1, 1, 0, 0, 77);
      @(negedge clk);
      reset = 1'b1;
      sb_q.delete();
      @(negedge clk);
      #4;
      check("rst_drop_valid", 64'(out_valid), 64'(0));
      check("rst_drop_data", out_data, 64'(0));
      reset = 1'b0;
      force_hold = 1'b0;
      zero_model();
      set_lanes(12, 0);
      send_beat(6, 1, 1, 0, 0, 12);

      // Randomized traffic with random output backpressure.
      rand_rdy = 1'b1;
      for (int it = 0; it < 400; it++) begin
         if ($urandom_range(0, 49) == 0) begin
            pulse_clr();
         end else begin
            for (int k = 0; k < COL; k++) begin
               case ($urandom_range(0, 3))
                  0: v = int'($urandom_range(0, 600)) - 300;
                  1: begin
                     t16 = 16'($urandom);
                     v = int'(t16);
                  end
                  2: v = int'($urandom_range(0, 5000)) - 2500;
                  default: v = ($urandom_range(0, 1) != 0) ? 32767 : -32768;
               endcase
               lv[k] = v;
            end
            addr = int'($urandom_range(0, DEPTH - 1));
            send_beat(addr, 1'($urandom_range(0, 1)), ($urandom_range(0, 2) != 0),
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 15)), NOEXP);
         end
      end

      rand_rdy = 1'b0;
      for (int c = 0; c < 200 && sb_q.size() != 0; c++) @(negedge clk);
      idle(2);
      check("sb_drained", 64'(sb_q.size()), 64'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
